csi2_pkt_hdr_tx: RTL
====================

# csi2_pkt_hdr_tx

Transmit-side CSI-2 packet framer. Accepts packet descriptors (VC, DT, WC) and a 32-bit payload stream. Emits one 32-bit word stream containing each packet's header, with the 6-bit Hamming ECC computed over the 24 header bits, followed by the packet's payload words. It sits ahead of the lane distributor in the CSI-2 TX path and produces headers that `csi2_hamming_dec` on the receive side checks and corrects.

## Interface
Parameters:
- none

Ports:
- `clk_i` input 1 — clock; all logic on rising edge
- `rst_i` input 1 — reset, synchronous, active-high
- `hdr_valid_i` input 1 — descriptor valid
- `hdr_ready_o` output 1 — descriptor accepted when `hdr_valid_i && hdr_ready_o`
- `vc_i` input 2 — virtual channel
- `dt_i` input 6 — data type
- `wc_i` input 16 — word count (long packet) or short-packet data field
- `pld_valid_i` input 1 — payload word valid
- `pld_data_i` input 32 — payload bytes, byte 0 in [7:0]
- `pld_ready_o` output 1 — payload word accepted when `pld_valid_i && pld_ready_o`
- `data_o` output 32 — output word
- `valid_o` output 1 — output word valid
- `last_o` output 1 — marks the final word of a packet; qualified by `valid_o`
- `ready_i` input 1 — downstream ready; a transfer occurs when `valid_o && ready_i`

## Operation
- Header word: [7:0] = {vc, dt}; [23:8] = wc; [29:24] = ECC P5..P0; [31:30] = 0.
- ECC over header bits d[23:0]. Each P is the XOR of the listed bits:
  - P0: 0,1,2,4,5,7,10,11,13,16,20,21,22,23
  - P1: 0,1,3,4,6,8,10,12,14,17,20,21,22,23
  - P2: 0,2,3,5,6,9,11,12,15,18,20,21,22
  - P3: 1,2,3,7,8,9,13,14,15,19,20,21,23
  - P4: 4,5,6,7,8,9,16,17,18,19,20,22,23
  - P5: 10,11,12,13,14,15,16,17,18,19,21,22,23
- Packet class:
  - Short packet: dt < 6'h10. No payload.
  - Long packet: dt ≥ 6'h10. Payload word count N = (wc + 3) >> 2, computed in 17 bits; N ≤ 16384, held in a 15-bit down-counter.
- FSM:
  - IDLE: `hdr_ready_o`=1. On descriptor accept, latch vc/dt/wc, compute the header, and go to HDR.
  - HDR: header word sits in the output register. On header transfer: go to IDLE if the packet is short or N=0, otherwise go to PLD.
  - PLD: pass payload words through unmodified. Decrement N on each payload accept. The last payload word loads with `last_o`=1. After the last word transfers, go to IDLE.
- `last_o`=1 on the header word of a short packet or of a long packet with wc=0.
- Trailing bytes in a partial final word pass through untouched. No CRC footer is generated; a downstream block handles that.
- Payload words arriving outside PLD are not accepted (`pld_ready_o`=0).

## Timing
- Output register stage: `data_o`/`valid_o`/`last_o` load only when `!valid_o || ready_i`. While `valid_o && !ready_i`, all three hold stable.
- Header latency: descriptor accepted at cycle T → header on `data_o` with `valid_o`=1 at T+1.
- Payload latency: word accepted at T → appears at T+1.
- `pld_ready_o` = (state==PLD) && N≠0 && (!valid_o || ready_i). This is combinational and gives full throughput of one word per cycle.
- `hdr_ready_o` = (state==IDLE) && !rst_i. A new descriptor can be accepted in the same cycle the previous packet's last word transfers, which gives back-to-back packets with no bubble.
- Reset values: `valid_o`=0, `last_o`=0, `data_o`=0, state IDLE, counter 0, `hdr_ready_o`=0, `pld_ready_o`=0.
- Reset mid-packet: the partially sent packet is abandoned and no completion word is emitted. After reset the block waits for a new descriptor.

## Configuration
- `CSI2_TX_ERR_INJECT_EN` defined:
  - Adds inputs `inj_en_i` (1) and `inj_mask_i` (30), sampled at descriptor accept.
  - If `inj_en_i`=1, the header word [29:0] is XORed with `inj_mask_i` after ECC generation.
  - Payload words are never altered.
- Not defined: these ports are absent and the header is always the clean encoding.

## Test plan
- Short packet, vc=0 dt=0x01 wc=0x0000 → single word 0x07000001 with `last_o`=1, one cycle after accept.
- Long packet, vc=0 dt=0x2B wc=0x0004, payload 0xDEADBEEF:
  - Expected output: 0x3400042B, then 0xDEADBEEF with `last_o`=1.
- Long packet wc=5 with `ready_i` toggled 1/0 every cycle:
  - Exactly 2 payload words follow the header.
  - Words stay stable while stalled.
  - `last_o` is set on the second payload word only.
- Back-to-back descriptors (wc=0x0004 long, then short dt=0x00 wc=0):
  - Second header follows the first packet's last word with no idle cycle.
  - Short header is 0x00000000 with `last_o`=1.
- `rst_i` asserted during PLD with 3 words remaining:
  - Next cycle `valid_o`=0 and `pld_ready_o`=0.
  - After release, a new short packet is framed correctly.
- With `CSI2_TX_ERR_INJECT_EN`, dt=0x2B wc=0x0004, `inj_mask_i`=0x8:
  - Header is 0x34000423.
  - `csi2_hamming_dec` flags the error and corrects it back to 0x3400042B.

Source files
------------

// File: rtl/csi2_pkt_hdr_tx.sv
// csi2_pkt_hdr_tx - CSI-2 transmit packet framer.
// Takes a packet descriptor (VC, DT, WC) and builds the 32-bit packet header.
// The header carries the 6-bit Hamming ECC computed over its 24 data bits.
// Long packets (DT >= 0x10) are then followed by ceil(WC/4) payload words.
// Payload words pass through unmodified.
// All outputs come from a single output register that holds while stalled.
// Optional feature macro: CSI2_TX_ERR_INJECT_EN
//   When defined, adds inj_en_i/inj_mask_i.
//   These XOR a mask into header bits [29:0] for error-injection testing.
module csi2_pkt_hdr_tx (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hdr_valid_i,
    output logic        hdr_ready_o,
    input  logic [1:0]  vc_i,
    input  logic [5:0]  dt_i,
    input  logic [15:0] wc_i,
`ifdef CSI2_TX_ERR_INJECT_EN
    input  logic        inj_en_i,
    input  logic [29:0] inj_mask_i,
`endif
    input  logic        pld_valid_i,
    input  logic [31:0] pld_data_i,
    output logic        pld_ready_o,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        last_o,
    input  logic        ready_i
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PLD
    } state_t;

    state_t      state;
    logic [14:0] pld_cnt;
    logic [31:0] hdr_hold;

    logic        out_en;
    logic        hdr_acc;
    logic        pld_acc;
    logic [23:0] hdr_bits;
    logic [5:0]  hdr_ecc;
    logic [31:0] hdr_word;
    logic [14:0] new_cnt;

    // The output register may load when it is empty or its word leaves this cycle.
    assign out_en      = !valid_o || ready_i;
    assign hdr_ready_o = (state == IDLE) && !rst_i;
    assign pld_ready_o = (state == PLD) && (pld_cnt != 15'd0) && out_en && !rst_i;
    assign hdr_acc     = hdr_valid_i && hdr_ready_o;
    assign pld_acc     = pld_valid_i && pld_ready_o;

    // Build the header word, its ECC and the payload word count from the incoming descriptor.
    always_comb begin
        hdr_bits   = {wc_i, vc_i, dt_i};
        hdr_ecc[0] = hdr_bits[0] ^ hdr_bits[1] ^ hdr_bits[2] ^ hdr_bits[4] ^ hdr_bits[5] ^ hdr_bits[7]
                   ^ hdr_bits[10] ^ hdr_bits[11] ^ hdr_bits[13] ^ hdr_bits[16] ^ hdr_bits[20]
                   ^ hdr_bits[21] ^ hdr_bits[22] ^ hdr_bits[23];
        hdr_ecc[1] = hdr_bits[0] ^ hdr_bits[1] ^ hdr_bits[3] ^ hdr_bits[4] ^ hdr_bits[6] ^ hdr_bits[8]
                   ^ hdr_bits[10] ^ hdr_bits[12] ^ hdr_bits[14] ^ hdr_bits[17] ^ hdr_bits[20]
                   ^ hdr_bits[21] ^ hdr_bits[22] ^ hdr_bits[23];
        hdr_ecc[2] = hdr_bits[0] ^ hdr_bits[2] ^ hdr_bits[3] ^ hdr_bits[5] ^ hdr_bits[6] ^ hdr_bits[9]
                   ^ hdr_bits[11] ^ hdr_bits[12] ^ hdr_bits[15] ^ hdr_bits[18] ^ hdr_bits[20]
                   ^ hdr_bits[21] ^ hdr_bits[22];
        hdr_ecc[3] = hdr_bits[1] ^ hdr_bits[2] ^ hdr_bits[3] ^ hdr_bits[7] ^ hdr_bits[8] ^ hdr_bits[9]
                   ^ hdr_bits[13] ^ hdr_bits[14] ^ hdr_bits[15] ^ hdr_bits[19] ^ hdr_bits[20]
                   ^ hdr_bits[21] ^ hdr_bits[23];
        hdr_ecc[4] = hdr_bits[4] ^ hdr_bits[5] ^ hdr_bits[6] ^ hdr_bits[7] ^ hdr_bits[8] ^ hdr_bits[9]
                   ^ hdr_bits[16] ^ hdr_bits[17] ^ hdr_bits[18] ^ hdr_bits[19] ^ hdr_bits[20]
                   ^ hdr_bits[22] ^ hdr_bits[23];
        hdr_ecc[5] = hdr_bits[10] ^ hdr_bits[11] ^ hdr_bits[12] ^ hdr_bits[13] ^ hdr_bits[14]
                   ^ hdr_bits[15] ^ hdr_bits[16] ^ hdr_bits[17] ^ hdr_bits[18] ^ hdr_bits[19]
                   ^ hdr_bits[21] ^ hdr_bits[22] ^ hdr_bits[23];
        hdr_word   = {2'b00, hdr_ecc, hdr_bits};
`ifdef CSI2_TX_ERR_INJECT_EN
        if (inj_en_i) begin
            hdr_word[29:0] = hdr_word[29:0] ^ inj_mask_i;
        end
`endif
        // ceil(wc / 4) without a 17-bit add: quotient plus one if any bytes remain
        if (dt_i >= 6'h10) begin
            new_cnt = {1'b0, wc_i[15:2]} + {14'd0, (wc_i[1:0] != 2'b00)};
        end else begin
            new_cnt = 15'd0;
        end
    end

    // Framing FSM and output register.
    // The FSM returns to IDLE as soon as a packet's final word is loaded,
    // so the next header can follow it with no bubble.
    // HDR holds a header that was accepted while the output register was still stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            pld_cnt  <= 15'd0;
            hdr_hold <= 32'd0;
            data_o   <= 32'd0;
            valid_o  <= 1'b0;
            last_o   <= 1'b0;
        end else begin
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (hdr_acc) begin
                        pld_cnt <= new_cnt;
                        if (out_en) begin
                            data_o  <= hdr_word;
                            valid_o <= 1'b1;
                            last_o  <= (new_cnt == 15'd0);
                            state   <= (new_cnt == 15'd0) ? IDLE : PLD;
                        end else begin
                            hdr_hold <= hdr_word;
                            state    <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (out_en) begin
                        data_o  <= hdr_hold;
                        valid_o <= 1'b1;
                        last_o  <= (pld_cnt == 15'd0);
                        state   <= (pld_cnt == 15'd0) ? IDLE : PLD;
                    end
                end
                PLD: begin
                    if (pld_acc) begin
                        data_o  <= pld_data_i;
                        valid_o <= 1'b1;
                        last_o  <= (pld_cnt == 15'd1);
                        pld_cnt <= pld_cnt - 15'd1;
                        if (pld_cnt == 15'd1) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
